// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle control unit with an internal register file.
// Accepts instructions over a valid/ready handshake and sequences them
// through DECODE, EXECUTE, MEM_ACCESS and WRITE_BACK, driving registered
// operands/offset/opcode/selects to the ALU and data-memory datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   instr_valid  instr carries a valid instruction
//   instr        {type[2], dest, src1, src2, offset[DATA_WIDTH], opcode[4]}
//   instr_ready  high when idle and out of reset
//   result       ALU result / memory read data, sampled in WRITE_BACK
//   operand1/2, offset, opcode  registered datapath controls
//   sel1, sel3   datapath mux selects (std 1/0, load/store 0/1)
//   w_r          data-memory write strobe, high only in MEM_ACCESS of a store
//   retired      one-cycle pulse when an instruction completes
//   dbg_addr/dbg_data  combinational register file read port
module cu_multicycle #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_ADDR_BITS = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         instr_valid,
  input  logic [2+3*REG_ADDR_BITS+DATA_WIDTH+4-1:0]    instr,
  output logic                                         instr_ready,
  input  logic [DATA_WIDTH-1:0]                        result,
  output logic [DATA_WIDTH-1:0]                        operand1,
  output logic [DATA_WIDTH-1:0]                        operand2,
  output logic [DATA_WIDTH-1:0]                        offset,
  output logic [3:0]                                   opcode,
  output logic                                         sel1,
  output logic                                         sel3,
  output logic                                         w_r,
  output logic                                         retired,
  input  logic [REG_ADDR_BITS-1:0]                     dbg_addr,
  output logic [DATA_WIDTH-1:0]                        dbg_data
);

  localparam int unsigned NUM_REGS    = 2**REG_ADDR_BITS;
  localparam int          INSTR_WIDTH = 2+3*REG_ADDR_BITS+DATA_WIDTH+4;
  localparam int          OFF_LSB     = 4;
  localparam int          SRC2_LSB    = OFF_LSB + DATA_WIDTH;
  localparam int          SRC1_LSB    = SRC2_LSB + REG_ADDR_BITS;
  localparam int          DEST_LSB    = SRC1_LSB + REG_ADDR_BITS;
  localparam int          TYPE_LSB    = DEST_LSB + REG_ADDR_BITS;

  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    DECODE     = 5'b00010,
    EXECUTE    = 5'b00100,
    MEM_ACCESS = 5'b01000,
    WRITE_BACK = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    T_NOP   = 2'b00,
    T_STD   = 2'b01,
    T_LOAD  = 2'b10,
    T_STORE = 2'b11
  } itype_t;

  state_t                   state, state_n;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

  itype_t                   itype, in_type;
  logic [REG_ADDR_BITS-1:0] dest, src1, src2;
  logic                     accept, rf_we;

  logic [DATA_WIDTH-1:0]    op1_n, op2_n, off_n;
  logic [3:0]               opc_n;
  logic                     sel1_n, sel3_n, w_r_n, retired_n;

  assign itype   = itype_t'(instr_q[TYPE_LSB +: 2]);
  assign in_type = itype_t'(instr[TYPE_LSB +: 2]);
  assign dest    = instr_q[DEST_LSB +: REG_ADDR_BITS];
  assign src1    = instr_q[SRC1_LSB +: REG_ADDR_BITS];
  assign src2    = instr_q[SRC2_LSB +: REG_ADDR_BITS];

  assign instr_ready = (state == IDLE) && rst;
  assign accept      = instr_valid && instr_ready;
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      instr_q  <= '0;
      operand1 <= '0;
      operand2 <= '0;
      offset   <= '0;
      opcode   <= '1;
      sel1     <= 1'b0;
      sel3     <= 1'b0;
      w_r      <= 1'b0;
      retired  <= 1'b0;
    end else begin
      state    <= state_n;
      operand1 <= op1_n;
      operand2 <= op2_n;
      offset   <= off_n;
      opcode   <= opc_n;
      sel1     <= sel1_n;
      sel3     <= sel3_n;
      w_r      <= w_r_n;
      retired  <= retired_n;
      if (accept) instr_q <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_WIDTH'(i);
    end else if (rf_we) begin
      regs[dest] <= result;
    end
  end

  always_comb begin
    state_n   = state;
    op1_n     = operand1;
    op2_n     = operand2;
    off_n     = offset;
    opc_n     = opcode;
    sel1_n    = sel1;
    sel3_n    = sel3;
    w_r_n     = w_r;
    retired_n = 1'b0;
    rf_we     = 1'b0;
    case (state)
      IDLE: begin
        // NOPs retire straight from IDLE, so the type is taken from the
        // incoming word rather than the latched copy.
        if (accept) begin
          if (in_type == T_NOP) retired_n = 1'b1;
          else                  state_n   = DECODE;
        end
      end
      DECODE: begin
        state_n = EXECUTE;
        op1_n   = regs[src1];
        off_n   = instr_q[OFF_LSB +: DATA_WIDTH];
        opc_n   = instr_q[3:0];
        if (itype == T_STD) begin
          op2_n  = regs[src2];
          sel1_n = 1'b1;
          sel3_n = 1'b0;
        end else begin
          op2_n  = regs[dest];
          sel1_n = 1'b0;
          sel3_n = 1'b1;
        end
      end
      EXECUTE: begin
        case (itype)
          T_STD:   state_n = WRITE_BACK;
          T_LOAD:  state_n = MEM_ACCESS;
          T_STORE: begin
            state_n = MEM_ACCESS;
            w_r_n   = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
      MEM_ACCESS: begin
        if (itype == T_STORE) begin
          state_n   = IDLE;
          w_r_n     = 1'b0;
          retired_n = 1'b1;
        end else begin
          state_n = WRITE_BACK;
        end
      end
      WRITE_BACK: begin
        state_n   = IDLE;
        rf_we     = 1'b1;
        retired_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
        op1_n   = '0;
        op2_n   = '0;
        off_n   = '0;
        opc_n   = '1;
        sel1_n  = 1'b0;
        sel3_n  = 1'b0;
        w_r_n   = 1'b0;
      end
    endcase
  end

endmodule
